// File: rtl/dm_arb_pkg.sv
// Shared constants and address helpers for the data-memory arbiter.
package dm_arb_pkg;

   localparam logic M_PIPE = 1'b0;
   localparam logic M_AUX  = 1'b1;

   localparam int unsigned DM_DEPTH_WORDS = 32'd3072;

   function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
      return 30'(byte_addr >> 2);
   endfunction

   // Word index compared at full width so huge addresses never alias into range.
   function automatic logic is_oor(input logic [31:0] byte_addr, input logic [31:0] depth);
      return ({2'b00, word_idx(byte_addr)} >= depth);
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the word memory.
interface dm_arbiter_if;

   logic        m0_req;
   logic        m1_req;
   logic        m0_we;
   logic        m1_we;
   logic [31:0] m0_addr;
   logic [31:0] m1_addr;
   logic [31:0] m0_wdata;
   logic [31:0] m1_wdata;
   logic [31:0] m0_pc;
   logic [31:0] m1_pc;
   logic        m0_gnt;
   logic        m1_gnt;
   logic        m0_rvalid;
   logic        m1_rvalid;
   logic [31:0] m0_rdata;
   logic [31:0] m1_rdata;
   logic [1:0]  m_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
             m0_wdata, m1_wdata, m0_pc, m1_pc, mem_rdata,
      output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
             m_err, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
             m0_wdata, m1_wdata, m0_pc, m1_pc, mem_rdata,
      input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
             m_err, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input round-robin grant generator; the priority pointer lives in the caller.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       win_id,
   output logic       any
);

   // On a tie the master that did not win most recently goes first
   always_comb begin
      gnt    = 2'b00;
      win_id = 1'b0;
      any    = 1'b0;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            win_id = 1'b0;
            any    = 1'b1;
         end
         2'b10: begin
            gnt    = 2'b10;
            win_id = 1'b1;
            any    = 1'b1;
         end
         2'b11: begin
            gnt    = last ? 2'b01 : 2'b10;
            win_id = ~last;
            any    = 1'b1;
         end
         default: begin
            gnt    = 2'b00;
            win_id = 1'b0;
            any    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the word data memory between MEM stage and an aux master.
// Define DM_ARB_TRACE_EN to print every performed memory write.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS
) (
   input logic         clk,
   input logic         reset,
   dm_arbiter_if.slave bus
);

   logic [1:0]  w_req;
   logic [1:0]  w_gnt;
   logic        w_win;
   logic        w_any;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [31:0] w_sel_pc;
   logic        w_oor;
   logic [31:0] w_rd;
   logic        w_unused;

   logic        r_last;
   logic [1:0]  r_rvalid;
   logic [1:0]  r_err;
   logic [31:0] r_rdata [2];

   // Requests are masked while reset is held so nothing reaches the memory.
   assign w_req = {bus.m1_req, bus.m0_req} & {2{reset}};

   rr_arb2 u_rr_arb2 (
      .req    (w_req),
      .last   (r_last),
      .gnt    (w_gnt),
      .win_id (w_win),
      .any    (w_any)
   );

   assign bus.m0_gnt = w_gnt[M_PIPE];
   assign bus.m1_gnt = w_gnt[M_AUX];

   // Steer the winner's request fields
   always_comb begin
      if (w_win == M_AUX) begin
         w_sel_we    = bus.m1_we;
         w_sel_addr  = bus.m1_addr;
         w_sel_wdata = bus.m1_wdata;
         w_sel_pc    = bus.m1_pc;
      end else begin
         w_sel_we    = bus.m0_we;
         w_sel_addr  = bus.m0_addr;
         w_sel_wdata = bus.m0_wdata;
         w_sel_pc    = bus.m0_pc;
      end
   end

   assign w_oor    = is_oor(w_sel_addr, 32'(DEPTH_WORDS));
   assign w_rd     = w_oor ? 32'h0000_0000 : bus.mem_rdata;
   assign w_unused = ^w_sel_pc;

   // Memory drive; idle bus is all zero
   always_comb begin
      if (w_any) begin
         bus.mem_we    = w_sel_we & ~w_oor;
         bus.mem_addr  = {word_idx(w_sel_addr), 2'b00};
         bus.mem_wdata = w_sel_wdata;
      end else begin
         bus.mem_we    = 1'b0;
         bus.mem_addr  = 32'h0000_0000;
         bus.mem_wdata = 32'h0000_0000;
      end
   end

   // Priority pointer, read return and error pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last     <= 1'b1;
         r_rvalid   <= 2'b00;
         r_err      <= 2'b00;
         r_rdata[0] <= 32'h0000_0000;
         r_rdata[1] <= 32'h0000_0000;
      end else begin
         r_rvalid <= 2'b00;
         r_err    <= 2'b00;
         if (w_any) begin
            r_last       <= w_win;
            r_err[w_win] <= w_oor;
            if (!w_sel_we) begin
               r_rvalid[w_win] <= 1'b1;
               r_rdata[w_win]  <= w_rd;
            end
         end
      end
   end

   assign bus.m0_rvalid = r_rvalid[M_PIPE];
   assign bus.m1_rvalid = r_rvalid[M_AUX];
   assign bus.m0_rdata  = r_rdata[M_PIPE];
   assign bus.m1_rdata  = r_rdata[M_AUX];
   assign bus.m_err     = r_err;

`ifdef DM_ARB_TRACE_EN
   // Trace performed writes at the edge that commits them
   always @(posedge clk) begin
      if (reset && bus.mem_we) begin
         $display("%d@%h: *%h <= %h", $time, w_sel_pc, bus.mem_addr, bus.mem_wdata);
      end
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter against a behavioural model with its own memory image.
module tb_dm_arbiter;

   localparam int unsigned DEPTH = 3072;

   logic clk;
   logic reset;
   dm_arbiter_if bus ();

   dm_arbiter #(.DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory environment (written only by the DUT) ----------------
   logic [31:0] env_mem [DEPTH];
   bit          env_wr  [DEPTH];

   function automatic logic [31:0] init_val(input int unsigned idx);
      return 32'h9E37_79B9 * (idx + 32'd1);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we && (bus.mem_addr[31:2] < 30'(DEPTH))) begin
         env_mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
         env_wr[bus.mem_addr[13:2]]  <= 1'b1;
      end
   end

   assign bus.mem_rdata = (bus.mem_addr[31:2] < 30'(DEPTH)) ?
                          (env_wr[bus.mem_addr[13:2]] ? env_mem[bus.mem_addr[13:2]]
                                                      : init_val(32'(bus.mem_addr[13:2])))
                          : 32'hBAD0_0BAD;

   // ---------------- behavioural model ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_mem [DEPTH];
   bit          model_wr  [DEPTH];
   int          last_winner;
   bit   [1:0]  e_rvalid;
   bit   [1:0]  e_err;
   logic [31:0] e_rdata [2];
   logic [1:0]  cap_gnt;
   logic        cap_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      last_winner = 1;
      e_rvalid    = 2'b00;
      e_err       = 2'b00;
      e_rdata[0]  = 32'h0;
      e_rdata[1]  = 32'h0;
   endtask

   // Called mid-cycle: compare every output, then work out what the next edge must produce.
   task automatic check_and_advance();
      int          w;
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      bit          inr;
      int unsigned idx;
      logic [1:0]  eg;
      cap_gnt = {bus.m1_gnt, bus.m0_gnt};
      cap_we  = bus.mem_we;
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(e_rvalid[0]));
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e_rvalid[1]));
      chk("m0_rdata", bus.m0_rdata, e_rdata[0]);
      chk("m1_rdata", bus.m1_rdata, e_rdata[1]);
      chk("m_err", 32'(bus.m_err), 32'(e_err));
      w = -1;
      if (reset) begin
         if (bus.m0_req && bus.m1_req) w = 1 - last_winner;
         else if (bus.m0_req)          w = 0;
         else if (bus.m1_req)          w = 1;
      end
      a   = (w == 1) ? bus.m1_addr  : bus.m0_addr;
      wd  = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
      we  = (w == 1) ? bus.m1_we    : bus.m0_we;
      idx = a / 4;
      inr = (a / 4) < DEPTH;
      eg  = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
      chk("gnt", 32'(cap_gnt), 32'(eg));
      chk("mem_we", 32'(bus.mem_we), 32'((w >= 0) && we && inr));
      chk("mem_addr", bus.mem_addr, (w >= 0) ? (a / 4) * 4 : 32'h0);
      chk("mem_wdata", bus.mem_wdata, (w >= 0) ? wd : 32'h0);
      e_rvalid = 2'b00;
      e_err    = 2'b00;
      if (w >= 0) begin
         last_winner = w;
         e_err[w]    = !inr;
         if (we) begin
            if (inr) begin
               model_mem[idx] = wd;
               model_wr[idx]  = 1'b1;
            end
         end else begin
            e_rvalid[w] = 1'b1;
            e_rdata[w]  = !inr ? 32'h0 : (model_wr[idx] ? model_mem[idx] : init_val(idx));
         end
      end
      if (!reset) model_reset();
   endtask

   task automatic cycle();
      @(negedge clk);
      check_and_advance();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 8) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 9) return 32'($urandom_range(DEPTH, DEPTH + 64)) << 2;
      else            return $urandom | 32'h8000_0000;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset        = 1'b0;
      bus.m0_req   = 1'b1;  bus.m1_req   = 1'b1;
      bus.m0_we    = 1'b0;  bus.m1_we    = 1'b0;
      bus.m0_addr  = 32'h0; bus.m1_addr  = 32'h4;
      bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
      bus.m0_pc    = 32'h100; bus.m1_pc  = 32'h200;

      // Reset held with both requesting
      cycle();
      cycle();
      chk("rst_gnt", 32'(cap_gnt), 32'h0);
      chk("rst_mem_we", 32'(cap_we), 32'h0);
      chk("rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h0);

      // Release: m0 wins the first tie, then strict alternation
      reset = 1'b1;
      cycle();
      chk("alt0", 32'(cap_gnt), 32'h1);
      cycle();
      chk("alt1", 32'(cap_gnt), 32'h2);
      cycle();
      chk("alt2", 32'(cap_gnt), 32'h1);
      cycle();
      chk("alt3", 32'(cap_gnt), 32'h2);

      // m0 writes, m1 reads the same word next cycle
      bus.m1_req = 1'b0;
      bus.m0_we = 1'b1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hDEAD_BEEF;
      cycle();
      chk("wr_gnt", 32'(cap_gnt), 32'h1);
      chk("wr_mem_we", 32'(cap_we), 32'h1);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h10;
      cycle();
      chk("rd_gnt", 32'(cap_gnt), 32'h2);
      chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'h1);
      chk("rd_m1_rdata", bus.m1_rdata, 32'hDEAD_BEEF);
      chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);

      // m1 alone for three cycles
      bus.m1_addr = 32'h24;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("solo_m1", 32'(cap_gnt), 32'h2);
      end
      bus.m1_req = 1'b0;

      // Out-of-range write then read
      bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h3000; bus.m0_wdata = 32'h1234_5678;
      cycle();
      chk("oor_wr_gnt", 32'(cap_gnt), 32'h1);
      chk("oor_wr_mem_we", 32'(cap_we), 32'h0);
      chk("oor_wr_err", 32'(bus.m_err), 32'h1);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h3004;
      cycle();
      chk("oor_rd_rdata", bus.m1_rdata, 32'h0);
      chk("oor_rd_err", 32'(bus.m_err), 32'h2);
      bus.m1_req = 1'b0;
      cycle();

      // Reset lands between a granted read and its return edge
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h20;
      @(negedge clk);
      check_and_advance();
      chk("midrd_gnt", 32'(cap_gnt), 32'h1);
      #2;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      bus.m0_req = 1'b0;
      chk("midrd_rvalid", 32'(bus.m0_rvalid), 32'h0);
      chk("midrd_rdata", bus.m0_rdata, 32'h0);
      cycle();
      reset = 1'b1;
      cycle();
      chk("midrd_rvalid2", 32'(bus.m0_rvalid), 32'h0);

      // Random traffic; a pending request keeps its fields until granted
      for (int c = 0; c < 600; c++) begin
         if (!(bus.m0_req && !cap_gnt[0])) begin
            bus.m0_req   = ($urandom_range(0, 3) != 0);
            bus.m0_we    = 1'($urandom_range(0, 1));
            bus.m0_addr  = rand_addr();
            bus.m0_wdata = $urandom;
            bus.m0_pc    = $urandom;
         end
         if (!(bus.m1_req && !cap_gnt[1])) begin
            bus.m1_req   = ($urandom_range(0, 3) != 0);
            bus.m1_we    = 1'($urandom_range(0, 1));
            bus.m1_addr  = rand_addr();
            bus.m1_wdata = $urandom;
            bus.m1_pc    = $urandom;
         end
         cycle();
      end
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      cycle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single-port word data memory between the pipeline MEM stage (master 0) and a secondary bus master such as a loader or debug port (master 1). It grants one access per cycle using round-robin priority and forwards the winner's address, write data and write enable to the memory. It registers the memory read data back to the winning master one cycle later. The block sits between the MEM-stage datapath and the `dm` instance.

## Interface
- `DEPTH_WORDS`, 3072: number of 32-bit words in the memory; word indices at or above this value are out of range.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; must be held, with all request fields stable, until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  byte address; bits [1:0] are ignored.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_pc`, `m1_pc`  in  32  PC tag, used only for the trace.
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; the access completes in the cycle where `req & gnt` is high.
- `m0_rvalid`, `m1_rvalid`  out  1  registered one-cycle pulse; read data is valid.
- `m0_rdata`, `m1_rdata`  out  32  registered read data; holds its value between pulses.
- `m_err`  out  2  registered; bit i pulses for one cycle after master i completes an out-of-range access.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned byte address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  combinational memory read data for `mem_addr`.

## Operation
- **Winner selection, each cycle**
  - Exactly one master requesting: that master is granted.
  - Both requesting: the master not granted most recently wins.
  - Neither requesting: no grant.
- **Priority pointer `last`**: a 1-bit register that updates to the winner's ID on every grant. It holds when there is no grant.
- **Memory drive**: `mem_addr`, `mem_wdata` and `mem_we` come from the winner.
  - With no winner: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Range check**: an access is out of range when `addr[31:2] >= DEPTH_WORDS`.
  - Out-of-range write: `mem_we` is forced to 0.
  - Out-of-range read: returns 0.
  - Either case sets that master's `m_err` bit on the next cycle.
- **Read path**: on a granted read, the arbiter captures `mem_rdata` (or 0 when out of range) into the winner's `rdata` register and pulses that master's `rvalid` on the next cycle.
- **Write path**: a write produces no `rvalid`.
- **Back-to-back accesses**: one access per cycle with no bubbles. A master may be re-granted in consecutive cycles only while the other master is not requesting.
- **Internal state**
  - `last` pointer.
  - Per-master pending-read flags, which drive `rvalid`.
  - Per-master error flags.
  - Per-master `rdata` registers.

## Timing
- **Grant latency**: 0 cycles; `gnt` is a combinational function of `req` and `last`.
- **Write latency**: the memory is written at the rising edge ending the grant cycle.
- **Read latency**: `rvalid` and `rdata` appear exactly 1 cycle after the grant cycle.
- **Asynchronous reset (`reset` = 0)**
  - Clears `last` to 1, so master 0 wins the first tie.
  - Clears `rvalid` and `m_err` to 0 and `rdata` to 0.
- **Reset mid-read**: the pending `rvalid` is dropped and never appears.
- **Reset while low**: `gnt` = 0 and `mem_we` = 0 regardless of `req`.
- **Write followed by read of the same address in the next cycle**: the read returns the newly written data.

## Configuration
- **`DM_ARB_TRACE_EN` defined**: every memory write that is performed prints, at the clock edge where it takes effect, `"%d@%h: *%h <= %h"` with `$time`, the winner's pc, `mem_addr` and `mem_wdata`.
  - Out-of-range writes print nothing.
- **`DM_ARB_TRACE_EN` undefined**: no display statements are compiled; the logic is otherwise identical.

## Structure
- **Package `dm_arb_pkg`**
  - Master-ID constants `M_PIPE` = 0 and `M_AUX` = 1.
  - Default `DM_DEPTH_WORDS` = 3072.
  - Word-index helper function.
- **Sub-module `rr_arb2`**
  - Purely a two-input round-robin grant generator.
  - Inputs: `req[1:0]`, `last`. Outputs: `gnt[1:0]`, `win_id`, `any`.
  - `dm_arbiter` owns the `last` register.

## Test plan
- **Reset**: hold `reset` low with both `req` = 1 → `gnt` = 00, `mem_we` = 0, `rvalid` = 00. Release reset with both requesting → m0 granted first.
- **Alternation**: both masters request continuously → grants alternate m0, m1, m0, m1 on four consecutive cycles.
- **Master 0 write, master 1 read**: m0 writes 0xDEADBEEF to 0x10, then m1 reads 0x10 in the next cycle → `m1_rvalid` pulses with `m1_rdata` = 0xDEADBEEF, and `m0_rvalid` stays 0.
- **Solo requester**: m1 requests alone for 3 cycles → granted on all 3 cycles.
- **Out of range**: m0 writes to 0x3000 (word 3072) → `mem_we` = 0 and `m_err` = 01 on the next cycle. m1 reads 0x3004 → `m1_rdata` = 0 and `m_err` = 10.
- **Reset mid-read**: grant an m0 read, then assert `reset` before the next edge → `m0_rvalid` never pulses and `rdata` = 0.
